mbist_march_ctrl: RTL and testbench

March C- built-in self-test controller for the single-port `fault_mem` array. On a start pulse it sequences every word of the array through the six March C- elements with solid all-0/all-1 backgrounds. It compares each read against the expected value, records the first failing address and element, and counts mismatches. It sits between the top-level test logic (start/done/pass) and the memory's `write_read`/`address`/`wdata`/`rdata` pins, and owns those pins exclusively while busy.

---
 rtl/mbist_march_ctrl_if.sv | 30 +++
 rtl/mbist_march_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_ctrl_if.sv
// Signal bundle between the March C- BIST controller, the top-level test logic
// and the single-port memory pins.
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [2:0]            fail_elem;
  logic [7:0]            err_count;
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    input  start, rdata,
    output busy, done, pass, fail_addr, fail_elem, err_count,
           write_read, address, wdata
  );

  modport slave (
    output start, rdata,
    input  busy, done, pass, fail_addr, fail_elem, err_count,
           write_read, address, wdata
  );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- self-test sequencer: walks six elements over the memory, compares reads
// two cycles later and keeps first-failure address/element plus a saturating count.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int CAPACITY   = 72
) (
  input logic                clk,
  input logic                rst,
  mbist_march_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    M0    = 4'd0,
    M1    = 4'd1,
    M2    = 4'd2,
    M3    = 4'd3,
    M4    = 4'd4,
    M5    = 4'd5,
    DRAIN = 4'd6,
    DONE  = 4'd7,
    IDLE  = 4'd8
  } state_t;

  typedef struct packed {
    state_t                state;
    logic                  phase;
    logic [ADDR_WIDTH-1:0] addr;
  } op_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(CAPACITY - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  state_t                state_q;
  logic                  phase_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  busy_q, done_q, pass_q, first_seen;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [2:0]            fail_elem_q;
  logic [7:0]            err_q, err_nxt;
  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_exp, s2_exp;
  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [2:0]            s1_elem, s2_elem;
  logic                  accept, mismatch;
  op_t                   cur, n1, n2;

  // Advance one op; the phase bit doubles as the two-cycle drain counter.
  function automatic op_t step(input op_t c);
    op_t n;
    n = c;
    case (c.state)
      M0, M5: begin
        if (c.addr == LAST) begin
          n.state = (c.state == M0) ? M1 : DRAIN;
          n.addr  = '0;
          n.phase = 1'b0;
        end else begin
          n.addr = c.addr + 1'b1;
        end
      end
      M1, M2: begin
        if (!c.phase) begin
          n.phase = 1'b1;
        end else if (c.addr == LAST) begin
          n.phase = 1'b0;
          n.state = (c.state == M1) ? M2 : M3;
          n.addr  = (c.state == M1) ? '0 : LAST;
        end else begin
          n.phase = 1'b0;
          n.addr  = c.addr + 1'b1;
        end
      end
      M3, M4: begin
        if (!c.phase) begin
          n.phase = 1'b1;
        end else if (c.addr == '0) begin
          n.phase = 1'b0;
          n.state = (c.state == M3) ? M4 : M5;
          n.addr  = (c.state == M3) ? LAST : '0;
        end else begin
          n.phase = 1'b0;
          n.addr  = c.addr - 1'b1;
        end
      end
      DRAIN: begin
        n.phase = ~c.phase;
        if (c.phase) n.state = DONE;
      end
      default: n = c;
    endcase
    return n;
  endfunction

  function automatic logic is_write(input state_t s, input logic p);
    return (s == M0) || (p && (s == M1 || s == M2 || s == M3 || s == M4));
  endfunction

  function automatic logic is_read(input state_t s, input logic p);
    return (s == M5) || (!p && (s == M1 || s == M2 || s == M3 || s == M4));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] op_data(input state_t s, input logic p);
    logic [DATA_WIDTH-1:0] d;
    case (s)
      M1, M3:  d = p ? ONES : ZERO;
      M2, M4:  d = p ? ZERO : ONES;
      default: d = ZERO;
    endcase
    return d;
  endfunction

  // n1 is the op presented next cycle; n2 the one after, for the wdata lookahead.
  always_comb begin
    accept    = bus.start && (state_q == IDLE || state_q == DONE);
    cur.state = state_q;
    cur.phase = phase_q;
    cur.addr  = addr_q;
    if (accept) begin
      n1.state = M0;
      n1.phase = 1'b0;
      n1.addr  = '0;
    end else begin
      n1 = step(cur);
    end
    n2       = step(n1);
    mismatch = s2_valid && (bus.rdata != s2_exp);
    err_nxt  = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      first_seen  <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_q       <= '0;
      s1_valid    <= 1'b0;
      s1_exp      <= '0;
      s1_addr     <= '0;
      s1_elem     <= '0;
      s2_valid    <= 1'b0;
      s2_exp      <= '0;
      s2_addr     <= '0;
      s2_elem     <= '0;
    end else begin
      state_q  <= n1.state;
      phase_q  <= n1.phase;
      addr_q   <= n1.addr;
      wr_q     <= is_write(n1.state, n1.phase);
      wdata_q  <= is_write(n2.state, n2.phase) ? op_data(n2.state, n2.phase) : ZERO;
      s1_valid <= is_read(state_q, phase_q);
      s1_exp   <= op_data(state_q, phase_q);
      s1_addr  <= addr_q;
      s1_elem  <= 3'(state_q);
      s2_valid <= s1_valid;
      s2_exp   <= s1_exp;
      s2_addr  <= s1_addr;
      s2_elem  <= s1_elem;
      if (accept) begin
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
        pass_q      <= 1'b0;
        first_seen  <= 1'b0;
        fail_addr_q <= '0;
        fail_elem_q <= '0;
        err_q       <= '0;
      end else begin
        err_q <= err_nxt;
        if (mismatch && !first_seen) begin
          first_seen  <= 1'b1;
          fail_addr_q <= s2_addr;
          fail_elem_q <= s2_elem;
        end
        if (state_q == DRAIN && n1.state == DONE) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (err_nxt == 8'd0);
        end
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_elem  = fail_elem_q;
  assign bus.err_count  = err_q;
  assign bus.write_read = wr_q;
  assign bus.address    = addr_q;
  assign bus.wdata      = wdata_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: fault-injecting memory model, op-sequence
// monitor built from element op counts, and a second 128-word instance for saturation.
module tb_mbist_march_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 7;
  localparam int CAP  = 72;
  localparam int CAP2 = 128;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Every word of the big instance reads back as all ones.
  assign bus_b.rdata = 8'hFF;

  logic [7:0]    mem [0:127];
  logic [7:0]    mem_wdata_q;
  logic [7:0]    mem_rd_q;
  logic          sa1_en, sa0_en;
  logic [AW-1:0] sa1_addr, sa0_addr;
  logic [7:0]    sa1_mask, sa0_mask;

  function automatic logic [7:0] faulted(input logic [7:0] d, input logic [AW-1:0] a);
    logic [7:0] r;
    r = d;
    if (sa1_en && a == sa1_addr) r = r | sa1_mask;
    if (sa0_en && a == sa0_addr) r = r & ~sa0_mask;
    return r;
  endfunction

  // wdata is registered a cycle ahead of the write; reads return two edges later.
  always @(posedge clk) begin
    mem_wdata_q <= bus_a.wdata;
    if (bus_a.write_read) mem[bus_a.address] <= mem_wdata_q;
    else                  mem_rd_q <= faulted(mem[bus_a.address], bus_a.address);
    bus_a.rdata <= mem_rd_q;
  end

  // Reference op at index i of a 72-word March C- run.
  task automatic model_op(input int i, output logic wr, output logic [AW-1:0] addr,
                          output logic [7:0] data);
    int j;
    data = 8'h00;
    if (i < 72) begin
      wr = 1'b1; addr = AW'(i);
    end else if (i < 216) begin
      j = i - 72;  wr = j[0]; addr = AW'(j / 2);      data = wr ? 8'hFF : 8'h00;
    end else if (i < 360) begin
      j = i - 216; wr = j[0]; addr = AW'(j / 2);      data = wr ? 8'h00 : 8'hFF;
    end else if (i < 504) begin
      j = i - 360; wr = j[0]; addr = AW'(71 - j / 2); data = wr ? 8'hFF : 8'h00;
    end else if (i < 648) begin
      j = i - 504; wr = j[0]; addr = AW'(71 - j / 2); data = wr ? 8'h00 : 8'hFF;
    end else begin
      j = i - 648; wr = 1'b0; addr = AW'(j);
    end
  endtask

  int            mon_idx;
  bit            mon_en;
  int            seq_err;
  logic [7:0]    prev_wdata;
  logic          m_wr, ta_wr0, ta_wr1;
  logic [AW-1:0] m_addr, ta_addr0, ta_addr1;
  logic [7:0]    m_data, ta_wdata1;

  always @(negedge clk) begin
    if (mon_en && mon_idx < 720) begin
      model_op(mon_idx, m_wr, m_addr, m_data);
      if (bus_a.write_read !== m_wr || bus_a.address !== m_addr) seq_err++;
      if (m_wr && prev_wdata !== m_data) seq_err++;
      if (mon_idx == 359) begin
        ta_wr0   = bus_a.write_read;
        ta_addr0 = bus_a.address;
      end
      if (mon_idx == 360) begin
        ta_wr1    = bus_a.write_read;
        ta_addr1  = bus_a.address;
        ta_wdata1 = bus_a.wdata;
      end
      mon_idx++;
    end
    prev_wdata = bus_a.wdata;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    mon_idx = 0;
    seq_err = 0;
    mon_en  = 1'b1;
    #1 bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(output int n, input int p1, input int p2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      bus_a.start = (n == p1 || n == p2);
    end while (!bus_a.done && n < 3000);
    bus_a.start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"}, bus_a.busy, 0);
    check_output({tag, "_done"}, bus_a.done, 0);
    check_output({tag, "_pass"}, bus_a.pass, 0);
    check_output({tag, "_fail_addr"}, bus_a.fail_addr, 0);
    check_output({tag, "_fail_elem"}, bus_a.fail_elem, 0);
    check_output({tag, "_err_count"}, bus_a.err_count, 0);
    check_output({tag, "_write_read"}, bus_a.write_read, 0);
    check_output({tag, "_address"}, bus_a.address, 0);
    check_output({tag, "_wdata"}, bus_a.wdata, 0);
  endtask

  int n;

  initial begin
    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    sa1_en = 1'b0; sa0_en = 1'b0;
    sa1_addr = '0; sa0_addr = '0; sa1_mask = '0; sa0_mask = '0;
    mon_en = 1'b0; mon_idx = 0; seq_err = 0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    $display("[TB] clean run with start pulses while busy");
    apply_stimulus();
    check_output("busy_after_start", bus_a.busy, 1);
    wait_done_a(n, 100, 400);
    check_output("clean_latency", n, 723);
    check_output("clean_busy_low", bus_a.busy, 0);
    check_output("clean_pass", bus_a.pass, 1);
    check_output("clean_err", bus_a.err_count, 0);
    check_output("clean_ops", mon_idx, 720);
    check_output("clean_seq", seq_err, 0);

    $display("[TB] stuck-at-1 bit 2 at address 35");
    sa1_en = 1'b1; sa1_addr = 7'd35; sa1_mask = 8'h04;
    apply_stimulus();
    check_output("rerun_done_cleared", bus_a.done, 0);
    wait_done_a(n, 0, 0);
    check_output("sa1_latency", n, 723);
    check_output("sa1_pass", bus_a.pass, 0);
    check_output("sa1_fail_addr", bus_a.fail_addr, 35);
    check_output("sa1_fail_elem", bus_a.fail_elem, 1);
    check_output("sa1_err", bus_a.err_count, 3);

    $display("[TB] stuck-at-0 bit 7 at address 71");
    sa1_en = 1'b0;
    sa0_en = 1'b1; sa0_addr = 7'd71; sa0_mask = 8'h80;
    apply_stimulus();
    check_output("clear_done", bus_a.done, 0);
    check_output("clear_err", bus_a.err_count, 0);
    check_output("clear_fail_addr", bus_a.fail_addr, 0);
    check_output("clear_fail_elem", bus_a.fail_elem, 0);
    wait_done_a(n, 0, 0);
    check_output("sa0_pass", bus_a.pass, 0);
    check_output("sa0_fail_addr", bus_a.fail_addr, 71);
    check_output("sa0_fail_elem", bus_a.fail_elem, 2);
    check_output("sa0_err", bus_a.err_count, 2);
    check_output("sa0_seq", seq_err, 0);
    check_output("turn_m2_last_op", {ta_wr0, ta_addr0}, {1'b1, 7'd71});
    check_output("turn_m3_first_op", {ta_wr1, ta_addr1}, {1'b0, 7'd71});
    check_output("turn_m3_wdata_lead", ta_wdata1, 8'hFF);

    $display("[TB] reset during M3 at address 40");
    sa0_en = 1'b0;
    apply_stimulus();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mon_idx >= 360 && bus_a.address == 7'd40) && n < 2000);
    check_output("m3_addr40_reached", {31'd0, n < 2000}, 1);
    #2 rst = 1'b1;
    mon_en = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus();
    wait_done_a(n, 0, 0);
    check_output("post_reset_latency", n, 723);
    check_output("post_reset_pass", bus_a.pass, 1);
    check_output("post_reset_err", bus_a.err_count, 0);
    check_output("post_reset_seq", seq_err, 0);

    $display("[TB] 128-word all-ones memory, count saturation");
    @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_b.done && n < 3000);
    check_output("sat_latency", n, 1283);
    check_output("sat_err", bus_b.err_count, 255);
    check_output("sat_pass", bus_b.pass, 0);
    check_output("sat_fail_addr", bus_b.fail_addr, 0);
    check_output("sat_fail_elem", bus_b.fail_elem, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
